// File: rtl/pipeline_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_seq_ctrl
// Brief    : Pipeline register / PC enable and bubble sequencer with
//            load-use, redirect, memory-wait, debug halt/step and counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_seq_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 32,
    parameter bit HALT_ON_RST = 1'b0
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic             exmem_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             dbg_halt,
    input  logic             dbg_step,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_bubble,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             dbg_halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int c_wait_w = $clog2(TIMEOUT_CYC);

    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT_CYC - 1);
    localparam logic [c_wait_w-1:0] c_wait_one  = c_wait_w'(1);
    localparam logic [CNT_W-1:0]    c_cnt_one   = CNT_W'(1);

    localparam logic [1:0] c_st_run   = 2'd0;
    localparam logic [1:0] c_st_mwait = 2'd1;
    localparam logic [1:0] c_st_halt  = 2'd2;
    localparam logic [1:0] c_st_step  = 2'd3;
    localparam logic [1:0] c_st_rst   = HALT_ON_RST ? c_st_halt : c_st_run;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic                r_ret_halt;
    logic                r_mem_err;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic w_mstall;
    logic w_lu;
    logic w_in_wait;
    logic w_wait_last;
    logic w_adv;
    logic w_timeout;

    logic w_pc_en;
    logic w_pc_redirect;
    logic w_if_id_en;
    logic w_id_ex_en;
    logic w_ex_mem_en;
    logic w_mem_wb_en;
    logic w_if_id_bubble;
    logic w_id_ex_bubble;
    logic w_ex_mem_bubble;

    assign w_mstall    = dmem_req & ~dmem_ready;
    assign w_lu        = idex_memread & (idex_rd != 5'd0) &
                         ((idex_rd == id_rs1) | (idex_rd == id_rs2));
    assign w_in_wait   = (r_state == c_st_mwait);
    assign w_wait_last = w_in_wait & (r_wait_cnt == c_wait_last);
    assign w_timeout   = w_wait_last & ~dmem_ready;

    // A memory wait ends either on ready or by forced advance at the timeout
    assign w_adv = ((r_state == c_st_run) | (r_state == c_st_step)) ? ~w_mstall
                 : (w_in_wait & (dmem_ready | w_wait_last));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= c_st_rst;
            r_wait_cnt  <= '0;
            r_ret_halt  <= 1'b0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt == c_st_mwait) && !w_in_wait) begin
                r_wait_cnt <= c_wait_one;
                r_ret_halt <= (r_state == c_st_step);
            end else if (w_in_wait && !w_adv) begin
                r_wait_cnt <= r_wait_cnt + c_wait_one;
            end
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
            if ((r_state != c_st_halt) && !w_pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (w_pc_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_run: begin
                if (w_mstall)      w_state_nxt = c_st_mwait;
                else if (dbg_halt) w_state_nxt = c_st_halt;
            end
            c_st_mwait: begin
                if (w_adv) w_state_nxt = (r_ret_halt | dbg_halt) ? c_st_halt : c_st_run;
            end
            c_st_halt: begin
                if (dbg_step)      w_state_nxt = c_st_step;
                else if (!dbg_halt) w_state_nxt = c_st_run;
            end
            c_st_step: begin
                w_state_nxt = w_mstall ? c_st_mwait : c_st_halt;
            end
            default: w_state_nxt = c_st_rst;
        endcase
    end

    // Redirect outranks load-use: the dependent instruction is flushed anyway
    always_comb begin
        w_pc_en         = 1'b0;
        w_pc_redirect   = 1'b0;
        w_if_id_en      = 1'b0;
        w_id_ex_en      = 1'b0;
        w_ex_mem_en     = 1'b0;
        w_mem_wb_en     = 1'b0;
        w_if_id_bubble  = 1'b0;
        w_id_ex_bubble  = 1'b0;
        w_ex_mem_bubble = 1'b0;
        if (w_adv) begin
            w_id_ex_en  = 1'b1;
            w_ex_mem_en = 1'b1;
            w_mem_wb_en = 1'b1;
            if (exmem_taken) begin
                w_pc_en         = 1'b1;
                w_if_id_en      = 1'b1;
                w_pc_redirect   = 1'b1;
                w_if_id_bubble  = 1'b1;
                w_id_ex_bubble  = 1'b1;
                w_ex_mem_bubble = 1'b1;
            end else if (w_lu) begin
                w_id_ex_bubble  = 1'b1;
            end else begin
                w_pc_en         = 1'b1;
                w_if_id_en      = 1'b1;
            end
        end
    end

    assign pc_en         = arst_n & w_pc_en;
    assign pc_redirect   = arst_n & w_pc_redirect;
    assign if_id_en      = arst_n & w_if_id_en;
    assign id_ex_en      = arst_n & w_id_ex_en;
    assign ex_mem_en     = arst_n & w_ex_mem_en;
    assign mem_wb_en     = arst_n & w_mem_wb_en;
    assign if_id_bubble  = arst_n & w_if_id_bubble;
    assign id_ex_bubble  = arst_n & w_id_ex_bubble;
    assign ex_mem_bubble = arst_n & w_ex_mem_bubble;
    assign dbg_halted    = (r_state == c_st_halt);
    assign mem_err       = r_mem_err;
    assign stall_cnt     = r_stall_cnt;
    assign flush_cnt     = r_flush_cnt;

endmodule
`default_nettype wire
